// File: rtl/reg_share_arb.sv
// Four-requester four-phase arbiter driving one shared bundled-data enable register.
// Define ARB_ROUND_ROBIN_EN for round-robin priority; the default build uses fixed priority (0 highest).
module reg_share_arb #(
  parameter int DATA_W    = 8,
  parameter int MATCH_CYC = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          req,
  input  logic [4*DATA_W-1:0] data_in,
  output logic [3:0]          ack,
  output logic [DATA_W-1:0]   reg_d,
  output logic                reg_en,
  output logic [1:0]          grant_id,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACK} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        ack_q, ack_d;
  logic [DATA_W-1:0] reg_d_q, reg_d_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic [1:0]        gid_q, gid_d;
  logic [1:0]        ptr_q;
  logic [1:0]        win_id, idx;
  logic              win_vld;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_d;

  assign ptr_d = (state_q == S_IDLE && win_vld) ? win_id : ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 2'd3;
    else       ptr_q <= ptr_d;
  end
`else
  // Pointer pinned at 3 makes the search below start at requester 0 every time.
  assign ptr_q = 2'd3;
`endif

  // Scan from ptr+4 down to ptr+1 so the nearest requester after the pointer wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = 2'd0;
    idx     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i) + 2'd1;
      if (req[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = ack_q;
    reg_d_d = reg_d_q;
    en_d    = en_q;
    gid_d   = gid_q;
    case (state_q)
      S_IDLE: begin
        ack_d = 4'd0;
        en_d  = 1'b0;
        if (win_vld) begin
          state_d = S_LOAD;
          reg_d_d = data_in[win_id*DATA_W +: DATA_W];
          gid_d   = win_id;
          en_d    = 1'b1;
          cnt_d   = 4'(MATCH_CYC - 1);
        end
      end
      S_LOAD: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          en_d    = 1'b0;
          ack_d   = 4'b0001 << gid_q;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!req[gid_q]) begin
          ack_d   = 4'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 4'd0;
      reg_d_q <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      gid_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      reg_d_q <= reg_d_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      gid_q   <= gid_d;
    end
  end

  assign ack      = ack_q;
  assign reg_d    = reg_d_q;
  assign reg_en   = en_q;
  assign grant_id = gid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_reg_share_arb.sv
// Bench: two arbiters (MATCH_CYC=2 and 1) checked every cycle against a transaction-level model.
module tb_reg_share_arb;

  logic clk, reset;
  logic [1:0][3:0]  req_v;
  logic [1:0][31:0] din_v;
  logic [1:0][3:0]  ack_v;
  logic [1:0][7:0]  regd_v;
  logic [1:0]       en_v;
  logic [1:0][1:0]  gid_v;
  logic [1:0]       busy_v;

  reg_share_arb #(.DATA_W(8), .MATCH_CYC(2)) dut0 (
    .clk(clk), .reset(reset), .req(req_v[0]), .data_in(din_v[0]), .ack(ack_v[0]),
    .reg_d(regd_v[0]), .reg_en(en_v[0]), .grant_id(gid_v[0]), .busy(busy_v[0]));

  reg_share_arb #(.DATA_W(8), .MATCH_CYC(1)) dut1 (
    .clk(clk), .reset(reset), .req(req_v[1]), .data_in(din_v[1]), .ack(ack_v[1]),
    .reg_d(regd_v[1]), .reg_en(en_v[1]), .grant_id(gid_v[1]), .busy(busy_v[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // A transaction is "active" from its grant edge; m_since counts edges after the grant
  // (saturating at MATCH_CYC). reg_en is high while since<MATCH_CYC, ack afterwards.
  bit         m_act  [2];
  int         m_since[2];
  logic [1:0] m_gid  [2];
  logic [1:0] m_ptr  [2];
  logic [7:0] m_regd [2];

  function automatic int mc(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  // Search begins one past the last grant; the pointer stays at 3 without round-robin.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    for (int k = 1; k <= 4; k++)
      if (r[(int'(p) + k) % 4]) return 2'((int'(p) + k) % 4);
    return 2'd0;
  endfunction

  function automatic logic [7:0] slice(input logic [31:0] v, input logic [1:0] g);
    return v[g*8 +: 8];
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_act[d]   <= 1'b0;
        m_since[d] <= 0;
        m_gid[d]   <= 2'd0;
        m_regd[d]  <= 8'd0;
        m_ptr[d]   <= 2'd3;
      end else if (!m_act[d]) begin
        if (req_v[d] != 4'd0) begin
          m_act[d]   <= 1'b1;
          m_since[d] <= 0;
          m_gid[d]   <= pick(req_v[d], m_ptr[d]);
          m_regd[d]  <= slice(din_v[d], pick(req_v[d], m_ptr[d]));
`ifdef ARB_ROUND_ROBIN_EN
          m_ptr[d]   <= pick(req_v[d], m_ptr[d]);
`endif
        end
      end else if (m_since[d] >= mc(d)) begin
        if (!req_v[d][m_gid[d]]) m_act[d] <= 1'b0;
      end else begin
        m_since[d] <= m_since[d] + 1;
      end
    end
  end

  // ---------------- checking ----------------
  typedef struct {
    string       nm;
    logic [31:0] act;
    logic [31:0] exp;
  } lit_t;
  lit_t litq[$];
  lit_t cur;
  int   n_chk, n_fail;
  bit   chk_on, done;

  function automatic void lit(input string nm, input logic [31:0] a, input logic [31:0] e);
    litq.push_back('{nm, a, e});
  endfunction

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        cmp($sformatf("dut%0d.reg_en", d), 32'(en_v[d]),
            32'(m_act[d] && m_since[d] < mc(d)));
        cmp($sformatf("dut%0d.ack", d), 32'(ack_v[d]),
            (m_act[d] && m_since[d] >= mc(d)) ? 32'(4'b0001 << m_gid[d]) : 32'd0);
        cmp($sformatf("dut%0d.busy", d), 32'(busy_v[d]), 32'(m_act[d]));
        cmp($sformatf("dut%0d.reg_d", d), 32'(regd_v[d]), 32'(m_regd[d]));
        cmp($sformatf("dut%0d.grant_id", d), 32'(gid_v[d]), 32'(m_gid[d]));
        cmp($sformatf("dut%0d.ack_onehot0", d), 32'($countones(ack_v[d]) <= 1), 32'd1);
      end
    end
    while (litq.size() > 0) begin
      cur = litq.pop_front();
      cmp(cur.nm, cur.act, cur.exp);
    end
    if (done) begin
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    req_v = '0;
    for (int c = 0; c < 20 && (busy_v != 2'b00); c++) step();
    lit("idle_reached", 32'(busy_v), 32'd0);
    step();
  endtask

  int         grants[$];
  int         exp_g[5];
  logic [3:0] mask;
  bit         prev_busy;

  initial begin
    reset = 1'b1; req_v = '0; din_v = '0;
    chk_on = 1'b0; done = 1'b0; n_chk = 0; n_fail = 0;
    step();
    lit("rst.ack", 32'(ack_v[0]), 32'd0);
    lit("rst.reg_en", 32'(en_v[0]), 32'd0);
    lit("rst.busy", 32'(busy_v[0]), 32'd0);
    lit("rst.reg_d", 32'(regd_v[0]), 32'd0);
    lit("rst.grant_id", 32'(gid_v[0]), 32'd0);
    reset = 1'b0;
    chk_on = 1'b1;
    step();

    // Basic handshake, MATCH_CYC=2: reg_en over edges 0-1, ack at edge 2, release at edge 5.
    req_v[0] = 4'b0001; din_v[0] = 32'h0000_00A5;
    step();
    lit("hs.e0.reg_d", 32'(regd_v[0]), 32'hA5);
    lit("hs.e0.model_reg_d", 32'(m_regd[0]), 32'hA5);
    lit("hs.e0.reg_en", 32'(en_v[0]), 32'd1);
    step();
    lit("hs.e1.reg_en", 32'(en_v[0]), 32'd1);
    step();
    lit("hs.e2.reg_en", 32'(en_v[0]), 32'd0);
    lit("hs.e2.ack", 32'(ack_v[0]), 32'b0001);
    step(); step();
    lit("hs.e4.ack", 32'(ack_v[0]), 32'b0001);
    req_v[0] = 4'b0000;
    step();
    lit("hs.e5.ack", 32'(ack_v[0]), 32'd0);
    lit("hs.e5.busy", 32'(busy_v[0]), 32'd0);
    idle_all();

    // MATCH_CYC=1: data changes right after the grant must not reach reg_d.
    req_v[1] = 4'b0001; din_v[1] = 32'h0000_003C;
    step();
    lit("m1.grant.reg_d", 32'(regd_v[1]), 32'h3C);
    lit("m1.grant.reg_en", 32'(en_v[1]), 32'd1);
    din_v[1] = 32'h0000_00FF;
    step();
    lit("m1.next.reg_en", 32'(en_v[1]), 32'd0);
    lit("m1.next.ack", 32'(ack_v[1]), 32'b0001);
    lit("m1.next.reg_d", 32'(regd_v[1]), 32'h3C);
    idle_all();

    // Request withdrawn during LOAD: ack pulses for one cycle.
    req_v[0] = 4'b0001;
    step();
    req_v[0] = 4'b0000;
    step(); step();
    lit("drop.ack", 32'(ack_v[0]), 32'b0001);
    step();
    lit("drop.ack_fall", 32'(ack_v[0]), 32'd0);
    lit("drop.busy", 32'(busy_v[0]), 32'd0);
    idle_all();

    // Arbitration order with requesters re-raising immediately after their handshake.
`ifdef ARB_ROUND_ROBIN_EN
    mask = 4'b1111; exp_g = '{0, 1, 2, 3, 0};
`else
    mask = 4'b1010; exp_g = '{1, 1, 1, 1, 1};
`endif
    grants.delete();
    prev_busy = 1'b0;
    req_v[0] = mask;
    for (int c = 0; c < 100 && grants.size() < 5; c++) begin
      step();
      if (busy_v[0] && !prev_busy) grants.push_back(int'(gid_v[0]));
      prev_busy = busy_v[0];
      for (int i = 0; i < 4; i++)
        if (mask[i]) begin
          if (ack_v[0][i])      req_v[0][i] = 1'b0;
          else if (!req_v[0][i]) req_v[0][i] = 1'b1;
        end
    end
    lit("order.count", 32'(grants.size()), 32'd5);
    for (int k = 0; k < 5 && k < grants.size(); k++)
      lit($sformatf("order.grant%0d", k), 32'(grants[k]), 32'(exp_g[k]));
    idle_all();

    // Reset mid-LOAD aborts at once; held request 2 is granted on the first edge after release.
    req_v[0] = 4'b0100;
    step();
    lit("rstmid.reg_en_before", 32'(en_v[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    lit("rstmid.reg_en", 32'(en_v[0]), 32'd0);
    lit("rstmid.ack", 32'(ack_v[0]), 32'd0);
    lit("rstmid.busy", 32'(busy_v[0]), 32'd0);
    lit("rstmid.reg_d", 32'(regd_v[0]), 32'd0);
    #2 reset = 1'b0;
    step();
    lit("rstmid.regrant_id", 32'(gid_v[0]), 32'd2);
    lit("rstmid.regrant_en", 32'(en_v[0]), 32'd1);
    idle_all();

    // Randomized four-phase requesters on both arbiters, with occasional withdrawal in LOAD.
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        din_v[d] = $urandom;
        for (int i = 0; i < 4; i++) begin
          if (!req_v[d][i] && !ack_v[d][i] && ($urandom_range(3) == 0)) req_v[d][i] = 1'b1;
          else if (req_v[d][i] && ack_v[d][i] && ($urandom_range(1) == 0)) req_v[d][i] = 1'b0;
          else if (req_v[d][i] && !ack_v[d][i] && ($urandom_range(39) == 0)) req_v[d][i] = 1'b0;
        end
      end
      step();
    end
    idle_all();
    done = 1'b1;
  end

endmodule
